// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single memory port, with a timeout abort.
// Define MEM_ARBITER_ROUND_ROBIN_EN for alternating priority; otherwise data always wins.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        if_req_valid_i,
    input  logic [31:0] if_req_addr_i,
    output logic        if_req_ready_o,
    output logic        if_rsp_valid_o,
    input  logic        dm_req_valid_i,
    input  logic [31:0] dm_req_addr_i,
    input  logic        dm_req_we_i,
    input  logic [1:0]  dm_req_size_i,
    input  logic [31:0] dm_req_wr_data_i,
    output logic        dm_req_ready_o,
    output logic        dm_rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [1:0]  mem_size_o,
    output logic [31:0] mem_wr_data_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rd_data_i
);

    // state | meaning
    // IDLE  | no transfer in flight; arbitrate and accept one request
    // BUSY  | memory request driven with latched fields; wait for ack or timeout
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        owner_dm_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] wr_data_q;
    logic [7:0]  cnt_q;
    logic        if_rsp_q, dm_rsp_q, err_q;
    logic [31:0] rsp_data_q;
    logic        grant_if, grant_dm;
    logic        prefer_dm;
    logic        timeout;

    assign timeout = (cnt_q == CNT_LAST);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_if_q;

    // Pointer reset value means "fetch granted last", so data wins the first tie.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            last_if_q <= 1'b1;
        else if (grant_if || grant_dm)
            last_if_q <= grant_if;
    end

    assign prefer_dm = last_if_q;
`else
    assign prefer_dm = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset_i) begin
                    if (dm_req_valid_i && (prefer_dm || !if_req_valid_i))
                        grant_dm = 1'b1;
                    else if (if_req_valid_i)
                        grant_if = 1'b1;
                    if (grant_if || grant_dm)
                        state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack_i || timeout)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            owner_dm_q <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            wr_data_q  <= '0;
            cnt_q      <= '0;
            if_rsp_q   <= 1'b0;
            dm_rsp_q   <= 1'b0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            if_rsp_q   <= 1'b0;
            dm_rsp_q   <= 1'b0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
            if (grant_if || grant_dm) begin
                owner_dm_q <= grant_dm;
                addr_q     <= grant_dm ? dm_req_addr_i : if_req_addr_i;
                we_q       <= grant_dm & dm_req_we_i;
                size_q     <= grant_dm ? dm_req_size_i : 2'd2;
                wr_data_q  <= grant_dm ? dm_req_wr_data_i : 32'd0;
                cnt_q      <= '0;
            end else if (state_q == BUSY) begin
                // Ack in the timeout cycle still completes normally.
                if (mem_ack_i) begin
                    if_rsp_q   <= ~owner_dm_q;
                    dm_rsp_q   <= owner_dm_q;
                    rsp_data_q <= we_q ? 32'd0 : mem_rd_data_i;
                end else if (timeout) begin
                    if_rsp_q <= ~owner_dm_q;
                    dm_rsp_q <= owner_dm_q;
                    err_q    <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    assign if_req_ready_o = grant_if;
    assign dm_req_ready_o = grant_dm;
    assign if_rsp_valid_o = if_rsp_q;
    assign dm_rsp_valid_o = dm_rsp_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_err_o      = err_q;
    assign mem_req_o      = (state_q == BUSY);
    assign mem_addr_o     = addr_q;
    assign mem_we_o       = we_q;
    assign mem_size_o     = size_q;
    assign mem_wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int TO = 16;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        if_req_valid_i;
    logic [31:0] if_req_addr_i;
    logic        if_req_ready_o, if_rsp_valid_o;
    logic        dm_req_valid_i;
    logic [31:0] dm_req_addr_i;
    logic        dm_req_we_i;
    logic [1:0]  dm_req_size_i;
    logic [31:0] dm_req_wr_data_i;
    logic        dm_req_ready_o, dm_rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [1:0]  mem_size_o;
    logic [31:0] mem_wr_data_o;
    logic        mem_ack_i;
    logic [31:0] mem_rd_data_i;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .if_req_valid_i(if_req_valid_i), .if_req_addr_i(if_req_addr_i),
        .if_req_ready_o(if_req_ready_o), .if_rsp_valid_o(if_rsp_valid_o),
        .dm_req_valid_i(dm_req_valid_i), .dm_req_addr_i(dm_req_addr_i),
        .dm_req_we_i(dm_req_we_i), .dm_req_size_i(dm_req_size_i),
        .dm_req_wr_data_i(dm_req_wr_data_i),
        .dm_req_ready_o(dm_req_ready_o), .dm_rsp_valid_o(dm_rsp_valid_o),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_size_o(mem_size_o), .mem_wr_data_o(mem_wr_data_o),
        .mem_ack_i(mem_ack_i), .mem_rd_data_i(mem_rd_data_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Reference model: one outstanding transaction plus one pending response.
    bit          m_busy, m_owner_dm, m_we, m_last_fetch;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_size;
    int          m_elapsed;
    bit          m_rsp_if, m_rsp_dm, m_rsp_err;
    logic [31:0] m_rsp_data;

    int obs_grant;     // 0 none, 1 fetch, 2 data
    bit obs_mem_req;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner_dm = 0; m_we = 0; m_last_fetch = 1;
        m_addr = 0; m_wdata = 0; m_size = 0; m_elapsed = 0;
        m_rsp_if = 0; m_rsp_dm = 0; m_rsp_err = 0; m_rsp_data = 0;
    endtask

    // One clock cycle: drive, check against model, advance model, wait for edge.
    task automatic step(input bit rst, input bit iv, input logic [31:0] ia,
                        input bit dv, input logic [31:0] da, input bit dwe,
                        input logic [1:0] dsz, input logic [31:0] dwd,
                        input bit ack, input logic [31:0] rd);
        int g;
        reset_i = rst; if_req_valid_i = iv; if_req_addr_i = ia;
        dm_req_valid_i = dv; dm_req_addr_i = da; dm_req_we_i = dwe;
        dm_req_size_i = dsz; dm_req_wr_data_i = dwd;
        mem_ack_i = ack; mem_rd_data_i = rd;
        #2;
        g = 0;
        if (!rst && !m_busy) begin
            if (iv && dv) g = RR ? (m_last_fetch ? 2 : 1) : 2;
            else if (dv)  g = 2;
            else if (iv)  g = 1;
        end
        check_val("if_ready", if_req_ready_o, 32'(g == 1));
        check_val("dm_ready", dm_req_ready_o, 32'(g == 2));
        check_val("mem_req", mem_req_o, 32'(m_busy));
        check_val("if_rsp", if_rsp_valid_o, 32'(m_rsp_if));
        check_val("dm_rsp", dm_rsp_valid_o, 32'(m_rsp_dm));
        check_val("rsp_data", rsp_data_o, m_rsp_data);
        check_val("rsp_err", rsp_err_o, 32'(m_rsp_err));
        if (m_busy) begin
            check_val("mem_addr", mem_addr_o, m_addr);
            check_val("mem_we", mem_we_o, 32'(m_we));
            check_val("mem_size", mem_size_o, 32'(m_size));
            check_val("mem_wdata", mem_wr_data_o, m_wdata);
        end
        obs_grant   = if_req_ready_o ? 1 : (dm_req_ready_o ? 2 : 0);
        obs_mem_req = mem_req_o;

        if (rst) begin
            model_reset();
        end else begin
            m_rsp_if = 0; m_rsp_dm = 0; m_rsp_err = 0; m_rsp_data = 0;
            if (m_busy) begin
                if (ack) begin
                    m_rsp_if = !m_owner_dm; m_rsp_dm = m_owner_dm;
                    m_rsp_data = m_we ? 32'd0 : rd;
                    m_busy = 0;
                end else if (m_elapsed + 1 == TO) begin
                    m_rsp_if = !m_owner_dm; m_rsp_dm = m_owner_dm;
                    m_rsp_err = 1;
                    m_busy = 0;
                end else begin
                    m_elapsed++;
                end
            end else if (g != 0) begin
                m_busy = 1; m_elapsed = 0;
                m_owner_dm = (g == 2);
                m_last_fetch = (g == 1);
                if (g == 2) begin
                    m_addr = da; m_we = dwe; m_size = dsz; m_wdata = dwd;
                end else begin
                    m_addr = ia; m_we = 0; m_size = 2; m_wdata = 0;
                end
            end
        end
        @(posedge clk_i); #1;
    endtask

    task automatic idle_step(input bit ack);
        step(0, 0, 32'h0, 0, 32'h0, 0, 2'd0, 32'h0, ack, 32'h1234_5678);
    endtask

    task automatic reset_step();
        step(1, 0, 32'h0, 0, 32'h0, 0, 2'd0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        int grants;
        int mreq_cnt;
        int exp_order[4];
        reset_i = 1; if_req_valid_i = 0; if_req_addr_i = 0;
        dm_req_valid_i = 0; dm_req_addr_i = 0; dm_req_we_i = 0;
        dm_req_size_i = 0; dm_req_wr_data_i = 0; mem_ack_i = 0; mem_rd_data_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        // Reset values, with a stray ack that must be ignored in IDLE
        check_val("rst_mem_addr", mem_addr_o, 32'h0);
        check_val("rst_mem_size", mem_size_o, 32'h0);
        check_val("rst_mem_wdata", mem_wr_data_o, 32'h0);
        idle_step(1);
        idle_step(0);

        // Lone fetch 0x100, ack on first BUSY cycle
        step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        check_val("fetch_rsp_data", rsp_data_o, 32'hDEAD_BEEF);
        idle_step(0);

        // Byte store, ack after two cycles
        step(0, 0, 0, 1, 32'h200, 1, 2'd0, 32'hA5, 0, 0);
        idle_step(0);
        idle_step(0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        check_val("store_rsp_data", rsp_data_o, 32'h0);
        idle_step(0);

        // Grant order with both requesting continuously
        reset_step();
        exp_order = RR ? '{2, 1, 2, 1} : '{2, 2, 2, 2};
        grants = 0;
        for (int i = 0; i < 40 && grants < 4; i++) begin
            step(0, 1, 32'h1000 + 32'(i), 1, 32'h2000 + 32'(i), 0, 2'd2, 0, m_busy, 32'(i));
            if (obs_grant != 0) begin
                check_val($sformatf("grant_%0d", grants), 32'(obs_grant), 32'(exp_order[grants]));
                grants++;
            end
        end
        check_val("grant_count", 32'(grants), 32'd4);
        idle_step(m_busy);
        idle_step(0);

        // Timeout: ack withheld
        step(0, 0, 0, 1, 32'h300, 0, 2'd1, 0, 0, 0);
        mreq_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            idle_step(0);
            if (obs_mem_req) mreq_cnt++;
        end
        check_val("timeout_len", 32'(mreq_cnt), 32'(TO));

        // Reset on 3rd BUSY cycle, then a normal request
        step(0, 1, 32'h400, 0, 0, 0, 0, 0, 0, 0);
        idle_step(0);
        idle_step(0);
        reset_step();
        idle_step(0);
        idle_step(0);
        step(0, 1, 32'h404, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D);
        check_val("post_rst_rsp", rsp_data_o, 32'h0BAD_F00D);

        // Back-to-back: new fetch accepted during the response cycle
        idle_step(0);
        step(0, 1, 32'h500, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) idle_step(0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5555_AAAA);
        step(0, 1, 32'h504, 0, 0, 0, 0, 0, 0, 0);
        check_val("b2b_accept", 32'(obs_grant), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1);
        idle_step(0);

        // Randomized phases: fast, slow, and stalled memory
        for (int ph = 0; ph < 3; ph++) begin
            int ack_pct;
            ack_pct = (ph == 0) ? 60 : ((ph == 1) ? 12 : 0);
            for (int i = 0; i < 700; i++) begin
                step($urandom_range(0, 199) == 0,
                     $urandom_range(0, 99) < 50, $urandom,
                     $urandom_range(0, 99) < 45, $urandom, 1'($urandom),
                     2'($urandom_range(0, 2)), $urandom,
                     $urandom_range(0, 99) < ack_pct, $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
